idu_pipelined: RTL and testbench

- Second-generation RV32I instruction decode unit between the fetch stage and the CU/ALU.
- Replaces edge-triggered decode with a single-clock, registered, valid/ready pipeline stage.
- Decodes the full RV32I base set plus FENCE, with complete legality checking.
- Tracks a parametrised history of issued destination registers and reports independent rs1/rs2 forwarding selects.

---
 rtl/idu_pipelined.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_idu_pipelined.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_pipelined.sv
// idu_pipelined: registered RV32I decode stage with a valid/ready handshake,
// full legality checking and rd-hazard history for rs1/rs2 forwarding selects.
module idu_pipelined #(
    parameter int unsigned HAZARD_DEPTH  = 2,
    parameter bit          SUPPORT_FENCE = 1'b1,
    parameter int unsigned FWD_W         = 2
) (
    input  logic             soc_clk,
    input  logic             reset,
    input  logic [31:0]      instruction,
    input  logic             fetch_valid,
    output logic             fetch_ready,
    input  logic             flush,
    input  logic             cu_ready,
    output logic             IDU_ready,
    output logic [5:0]       Instruction_to_CU,
    output logic [4:0]       Instruction_to_ALU,
    output logic [31:0]      imm,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       shamt,
    output logic [31:0]      pc_increment,
    output logic [FWD_W-1:0] fwd_rs1,
    output logic [FWD_W-1:0] fwd_rs2,
    output logic             invalid_instruction
);

    localparam logic [5:0] CuIllegal = 6'd63;
    localparam logic [4:0] AluNone   = 5'd16;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instruction[6:0];
    assign f3     = instruction[14:12];
    assign f7     = instruction[31:25];
    assign imm_i  = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s  = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b  = {{19{instruction[31]}}, instruction[31], instruction[7],
                     instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u  = {instruction[31:12], 12'd0};
    assign imm_j  = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                     instruction[20], instruction[30:21], 1'b0};

    logic [5:0]  d_cu;
    logic [4:0]  d_alu, d_rd, d_rs1, d_rs2, d_shamt;
    logic [31:0] d_imm, d_pc_inc;
    logic        d_writes, d_illegal, d_push_valid;
    logic [FWD_W-1:0] fwd1_d, fwd2_d;

    logic             ready_q;
    logic [5:0]       cu_q;
    logic [4:0]       alu_q, rd_q, rs1_q, rs2_q, shamt_q;
    logic [31:0]      imm_q, pc_inc_q;
    logic [FWD_W-1:0] fwd1_q, fwd2_q;
    logic             inv_q;
    logic [HAZARD_DEPTH-1:0] hist_valid_q;
    logic [4:0]              hist_rd_q [HAZARD_DEPTH];

    logic accept;

    assign fetch_ready = reset && !flush && (!ready_q || cu_ready);
    assign accept      = fetch_valid && fetch_ready;

    // Combinational decode of the fetch word; unused fields stay zero.
    always_comb begin
        d_cu      = CuIllegal;
        d_alu     = AluNone;
        d_imm     = 32'd0;
        d_rd      = 5'd0;
        d_rs1     = 5'd0;
        d_rs2     = 5'd0;
        d_shamt   = 5'd0;
        d_pc_inc  = 32'd4;
        d_writes  = 1'b0;
        d_illegal = 1'b0;
        case (opcode)
            7'b0110111, 7'b0010111: begin
                d_cu     = (opcode == 7'b0110111) ? 6'd0 : 6'd1;
                d_rd     = instruction[11:7];
                d_imm    = imm_u;
                d_writes = 1'b1;
            end
            7'b1101111: begin
                d_cu     = 6'd2;
                d_rd     = instruction[11:7];
                d_imm    = imm_j;
                d_pc_inc = imm_j;
                d_writes = 1'b1;
            end
            7'b1100111: begin
                d_cu      = 6'd3;
                d_rd      = instruction[11:7];
                d_rs1     = instruction[19:15];
                d_imm     = imm_i;
                d_writes  = 1'b1;
                d_illegal = (f3 != 3'b000);
            end
            7'b1100011: begin
                d_rs1 = instruction[19:15];
                d_rs2 = instruction[24:20];
                d_imm = imm_b;
                case (f3)
                    3'b000:  begin d_cu = 6'd4; d_alu = 5'd0; end
                    3'b001:  begin d_cu = 6'd5; d_alu = 5'd1; end
                    3'b100:  begin d_cu = 6'd6; d_alu = 5'd2; end
                    3'b101:  begin d_cu = 6'd7; d_alu = 5'd3; end
                    3'b110:  begin d_cu = 6'd8; d_alu = 5'd4; end
                    3'b111:  begin d_cu = 6'd9; d_alu = 5'd5; end
                    default: d_illegal = 1'b1;
                endcase
            end
            7'b0100011: begin
                d_rs1 = instruction[19:15];
                d_rs2 = instruction[24:20];
                d_imm = imm_s;
                case (f3)
                    3'b000:  d_cu = 6'd10;
                    3'b001:  d_cu = 6'd11;
                    3'b010:  d_cu = 6'd12;
                    default: d_illegal = 1'b1;
                endcase
            end
            7'b0000011: begin
                d_rd     = instruction[11:7];
                d_rs1    = instruction[19:15];
                d_imm    = imm_i;
                d_writes = 1'b1;
                case (f3)
                    3'b000:  d_cu = 6'd13;
                    3'b001:  d_cu = 6'd14;
                    3'b010:  d_cu = 6'd15;
                    3'b100:  d_cu = 6'd16;
                    3'b101:  d_cu = 6'd17;
                    default: d_illegal = 1'b1;
                endcase
            end
            7'b0010011: begin
                d_cu     = 6'd18;
                d_rd     = instruction[11:7];
                d_rs1    = instruction[19:15];
                d_writes = 1'b1;
                d_imm    = imm_i;
                case (f3)
                    3'b000: d_alu = 5'd6;
                    3'b010: d_alu = 5'd9;
                    3'b011: d_alu = 5'd10;
                    3'b100: d_alu = 5'd11;
                    3'b110: d_alu = 5'd14;
                    3'b111: d_alu = 5'd15;
                    3'b001: begin
                        d_alu     = 5'd8;
                        d_imm     = 32'd0;
                        d_shamt   = instruction[24:20];
                        d_illegal = (f7 != 7'b0000000);
                    end
                    default: begin
                        d_imm     = 32'd0;
                        d_shamt   = instruction[24:20];
                        d_alu     = (f7 == 7'b0100000) ? 5'd13 : 5'd12;
                        d_illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                    end
                endcase
            end
            7'b0110011: begin
                d_cu     = 6'd19;
                d_rd     = instruction[11:7];
                d_rs1    = instruction[19:15];
                d_rs2    = instruction[24:20];
                d_writes = 1'b1;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000: d_alu = 5'd6;
                        3'b001: d_alu = 5'd8;
                        3'b010: d_alu = 5'd9;
                        3'b011: d_alu = 5'd10;
                        3'b100: d_alu = 5'd11;
                        3'b101: d_alu = 5'd12;
                        3'b110: d_alu = 5'd14;
                        default: d_alu = 5'd15;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    d_alu = 5'd7;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    d_alu = 5'd13;
                end else begin
                    d_illegal = 1'b1;
                end
            end
            7'b1110011: begin
                if (instruction[31:7] == 25'd0) begin
                    d_cu = 6'd20;
                end else if (instruction[31:20] == 12'd1 && instruction[19:7] == 13'd0) begin
                    d_cu = 6'd21;
                end else begin
                    d_illegal = 1'b1;
                end
            end
            7'b0001111: begin
                // FENCE (funct3 000) and FENCE.I (funct3 001) share one CU code.
                if (SUPPORT_FENCE && (f3 == 3'b000 || f3 == 3'b001)) begin
                    d_cu = 6'd22;
                end else begin
                    d_illegal = 1'b1;
                end
            end
            default: d_illegal = 1'b1;
        endcase
        if (d_illegal) begin
            d_cu     = CuIllegal;
            d_alu    = AluNone;
            d_imm    = 32'd0;
            d_rd     = 5'd0;
            d_rs1    = 5'd0;
            d_rs2    = 5'd0;
            d_shamt  = 5'd0;
            d_pc_inc = 32'd4;
            d_writes = 1'b0;
        end
    end

    assign d_push_valid = d_writes && (d_rd != 5'd0);

    // Forwarding selects against pre-push history; scanning oldest first lets newest win.
    always_comb begin
        fwd1_d = '0;
        fwd2_d = '0;
        for (int k = HAZARD_DEPTH; k >= 1; k--) begin
            if (hist_valid_q[k-1] && d_rs1 != 5'd0 && hist_rd_q[k-1] == d_rs1) begin
                fwd1_d = FWD_W'(k);
            end
            if (hist_valid_q[k-1] && d_rs2 != 5'd0 && hist_rd_q[k-1] == d_rs2) begin
                fwd2_d = FWD_W'(k);
            end
        end
    end

    // Output stage and hazard history; flush and reset both empty the history.
    always_ff @(posedge soc_clk) begin
        if (!reset) begin
            ready_q      <= 1'b0;
            cu_q         <= CuIllegal;
            alu_q        <= AluNone;
            imm_q        <= 32'd0;
            rd_q         <= 5'd0;
            rs1_q        <= 5'd0;
            rs2_q        <= 5'd0;
            shamt_q      <= 5'd0;
            pc_inc_q     <= 32'd4;
            fwd1_q       <= '0;
            fwd2_q       <= '0;
            inv_q        <= 1'b0;
            hist_valid_q <= '0;
            for (int i = 0; i < HAZARD_DEPTH; i++) hist_rd_q[i] <= 5'd0;
        end else if (flush) begin
            ready_q      <= 1'b0;
            hist_valid_q <= '0;
        end else if (accept) begin
            ready_q  <= 1'b1;
            cu_q     <= d_cu;
            alu_q    <= d_alu;
            imm_q    <= d_imm;
            rd_q     <= d_rd;
            rs1_q    <= d_rs1;
            rs2_q    <= d_rs2;
            shamt_q  <= d_shamt;
            pc_inc_q <= d_pc_inc;
            fwd1_q   <= fwd1_d;
            fwd2_q   <= fwd2_d;
            inv_q    <= d_illegal;
            for (int i = HAZARD_DEPTH - 1; i > 0; i--) begin
                hist_valid_q[i] <= hist_valid_q[i-1];
                hist_rd_q[i]    <= hist_rd_q[i-1];
            end
            hist_valid_q[0] <= d_push_valid;
            hist_rd_q[0]    <= d_rd;
        end else if (cu_ready) begin
            ready_q <= 1'b0;
        end
    end

    assign IDU_ready           = ready_q;
    assign Instruction_to_CU   = cu_q;
    assign Instruction_to_ALU  = alu_q;
    assign imm                 = imm_q;
    assign rd                  = rd_q;
    assign rs1                 = rs1_q;
    assign rs2                 = rs2_q;
    assign shamt               = shamt_q;
    assign pc_increment        = pc_inc_q;
    assign fwd_rs1             = fwd1_q;
    assign fwd_rs2             = fwd2_q;
    assign invalid_instruction = inv_q;

endmodule

// File: tb/tb_idu_pipelined.sv
// Scoreboard bench for idu_pipelined: stimulus queues expected decodes on accept,
// a negedge monitor compares whenever IDU_ready is high and pops on consume.
module tb_idu_pipelined;

    localparam int FW = 2;

    logic          soc_clk = 1'b0;
    logic          reset;
    logic [31:0]   instruction;
    logic          fetch_valid;
    logic          fetch_ready;
    logic          flush;
    logic          cu_ready;
    logic          IDU_ready;
    logic [5:0]    Instruction_to_CU;
    logic [4:0]    Instruction_to_ALU;
    logic [31:0]   imm;
    logic [4:0]    rd, rs1, rs2, shamt;
    logic [31:0]   pc_increment;
    logic [FW-1:0] fwd_rs1, fwd_rs2;
    logic          invalid_instruction;

    idu_pipelined #(
        .HAZARD_DEPTH (2),
        .SUPPORT_FENCE(1'b1),
        .FWD_W        (FW)
    ) dut (
        .soc_clk            (soc_clk),
        .reset              (reset),
        .instruction        (instruction),
        .fetch_valid        (fetch_valid),
        .fetch_ready        (fetch_ready),
        .flush              (flush),
        .cu_ready           (cu_ready),
        .IDU_ready          (IDU_ready),
        .Instruction_to_CU  (Instruction_to_CU),
        .Instruction_to_ALU (Instruction_to_ALU),
        .imm                (imm),
        .rd                 (rd),
        .rs1                (rs1),
        .rs2                (rs2),
        .shamt              (shamt),
        .pc_increment       (pc_increment),
        .fwd_rs1            (fwd_rs1),
        .fwd_rs2            (fwd_rs2),
        .invalid_instruction(invalid_instruction)
    );

    always #5 soc_clk = ~soc_clk;

    typedef struct packed {
        logic [5:0]    cu;
        logic [4:0]    alu;
        logic [31:0]   imm;
        logic [4:0]    rd;
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic [4:0]    shamt;
        logic [31:0]   pc;
        logic [FW-1:0] f1;
        logic [FW-1:0] f2;
        logic          inv;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   pushed = 0;
    int   popped = 0;
    int   last_wait = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int cu, input int alu, input logic [31:0] im,
                                input int r_d, input int r_s1, input int r_s2, input int sh,
                                input logic [31:0] pc, input int f1, input int f2,
                                input int inv);
        exp_t e;
        e.cu    = 6'(cu);
        e.alu   = 5'(alu);
        e.imm   = im;
        e.rd    = 5'(r_d);
        e.rs1   = 5'(r_s1);
        e.rs2   = 5'(r_s2);
        e.shamt = 5'(sh);
        e.pc    = pc;
        e.f1    = FW'(f1);
        e.f2    = FW'(f2);
        e.inv   = 1'(inv);
        return e;
    endfunction

    // Monitor: compare the head of the scoreboard every cycle the output is valid.
    always @(negedge soc_clk) begin
        if (reset === 1'b1 && IDU_ready === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: IDU_ready=1 with nothing outstanding, CU=%0d",
                         Instruction_to_CU);
            end else begin
                mon_e = sb[0];
                chk("out_cu",    32'(Instruction_to_CU),   32'(mon_e.cu));
                chk("out_alu",   32'(Instruction_to_ALU),  32'(mon_e.alu));
                chk("out_imm",   imm,                      mon_e.imm);
                chk("out_rd",    32'(rd),                  32'(mon_e.rd));
                chk("out_rs1",   32'(rs1),                 32'(mon_e.rs1));
                chk("out_rs2",   32'(rs2),                 32'(mon_e.rs2));
                chk("out_shamt", 32'(shamt),               32'(mon_e.shamt));
                chk("out_pcinc", pc_increment,             mon_e.pc);
                chk("out_fwd1",  32'(fwd_rs1),             32'(mon_e.f1));
                chk("out_fwd2",  32'(fwd_rs2),             32'(mon_e.f2));
                chk("out_inv",   32'(invalid_instruction), 32'(mon_e.inv));
                if (cu_ready) begin
                    void'(sb.pop_front());
                    popped++;
                end
            end
        end
    end

    // Present one instruction until accepted (bounded); returns at posedge+1.
    task automatic send(input logic [31:0] ins, input exp_t e);
        int n;
        n = 0;
        instruction = ins;
        fetch_valid = 1'b1;
        @(negedge soc_clk);
        while (!fetch_ready && n < 20) begin
            n++;
            @(negedge soc_clk);
        end
        if (fetch_ready) begin
            sb.push_back(e);
            pushed++;
        end else begin
            tests++;
            fails++;
            $display("FAIL send_timeout: instruction 0x%08h never accepted, fetch_ready=%0b",
                     ins, fetch_ready);
        end
        last_wait = n;
        @(posedge soc_clk);
        #1;
        fetch_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        fetch_valid = 1'b0;
        repeat (n) @(posedge soc_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        flush       = 1'b0;
        cu_ready    = 1'b1;
        fetch_valid = 1'b1;
        instruction = 32'h123452B7;
        repeat (2) begin
            @(negedge soc_clk);
            chk("rst_idu_ready",   32'(IDU_ready),           32'd0);
            chk("rst_fetch_ready", 32'(fetch_ready),         32'd0);
            chk("rst_cu",          32'(Instruction_to_CU),   32'd63);
            chk("rst_alu",         32'(Instruction_to_ALU),  32'd16);
            chk("rst_fwd1",        32'(fwd_rs1),             32'd0);
            chk("rst_fwd2",        32'(fwd_rs2),             32'd0);
            chk("rst_imm",         imm,                      32'd0);
            chk("rst_pcinc",       pc_increment,             32'd4);
            chk("rst_inv",         32'(invalid_instruction), 32'd0);
        end
        @(posedge soc_clk);
        #1;
        reset = 1'b1;

        send(32'h123452B7, mk(0, 16, 32'h12345000, 5, 0, 0, 0, 32'd4, 0, 0, 0));   // lui x5
        send(32'h00500093, mk(18, 6, 32'd5, 1, 0, 0, 0, 32'd4, 0, 0, 0));         // addi x1,x0,5
        send(32'h00108133, mk(19, 6, 32'd0, 2, 1, 1, 0, 32'd4, 1, 1, 0));         // add x2,x1,x1
        chk("b2b_add_wait", 32'(last_wait), 32'd0);
        send(32'h401101B3, mk(19, 7, 32'd0, 3, 2, 1, 0, 32'd4, 1, 2, 0));         // sub x3,x2,x1
        chk("b2b_sub_wait", 32'(last_wait), 32'd0);
        send(32'hFE000EE3, mk(4, 0, 32'hFFFFFFFC, 0, 0, 0, 0, 32'd4, 0, 0, 0));   // beq -4
        send(32'hFFFFFFFF, mk(63, 16, 32'd0, 0, 0, 0, 0, 32'd4, 0, 0, 1));        // illegal
        send(32'h00108133, mk(19, 6, 32'd0, 2, 1, 1, 0, 32'd4, 0, 0, 0));         // add, no hazard

        // Backpressure: output must hold while cu_ready is low.
        idle(2);
        cu_ready = 1'b0;
        send(32'h00500093, mk(18, 6, 32'd5, 1, 0, 0, 0, 32'd4, 0, 0, 0));
        instruction = 32'h00108133;
        fetch_valid = 1'b1;
        repeat (3) begin
            @(negedge soc_clk);
            chk("bp_fetch_ready", 32'(fetch_ready), 32'd0);
            chk("bp_idu_ready",   32'(IDU_ready),   32'd1);
        end
        @(posedge soc_clk);
        #1;
        cu_ready = 1'b1;
        send(32'h00108133, mk(19, 6, 32'd0, 2, 1, 1, 0, 32'd4, 1, 1, 0));
        chk("bp_release_wait", 32'(last_wait), 32'd0);

        // Flush blocks the presented add and clears history.
        idle(2);
        send(32'h00500093, mk(18, 6, 32'd5, 1, 0, 0, 0, 32'd4, 0, 0, 0));
        instruction = 32'h00108133;
        fetch_valid = 1'b1;
        flush       = 1'b1;
        @(negedge soc_clk);
        chk("flush_fetch_ready", 32'(fetch_ready), 32'd0);
        @(posedge soc_clk);
        #1;
        flush       = 1'b0;
        fetch_valid = 1'b0;
        @(negedge soc_clk);
        chk("flush_idu_ready", 32'(IDU_ready), 32'd0);
        @(posedge soc_clk);
        #1;
        send(32'h00108133, mk(19, 6, 32'd0, 2, 1, 1, 0, 32'd4, 0, 0, 0));

        send(32'h00100073, mk(21, 16, 32'd0, 0, 0, 0, 0, 32'd4, 0, 0, 0));        // ebreak
        send(32'h00000073, mk(20, 16, 32'd0, 0, 0, 0, 0, 32'd4, 0, 0, 0));        // ecall
        send(32'h0000000F, mk(22, 16, 32'd0, 0, 0, 0, 0, 32'd4, 0, 0, 0));        // fence
        send(32'h40001033, mk(63, 16, 32'd0, 0, 0, 0, 0, 32'd4, 0, 0, 1));        // bad SLL
        send(32'h008000EF, mk(2, 16, 32'd8, 1, 0, 0, 0, 32'd8, 0, 0, 0));         // jal x1,8
        send(32'h4021D213, mk(18, 13, 32'd0, 4, 3, 0, 2, 32'd4, 0, 0, 0));        // srai x4,x3,2
        send(32'h0020A223, mk(12, 16, 32'd4, 0, 1, 2, 0, 32'd4, 2, 0, 0));        // sw x2,4(x1)

        idle(4);
        chk("sb_empty",      32'(sb.size()), 32'd0);
        chk("pushed_popped", 32'(popped),    32'(pushed));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
